// File: rtl/fetch_unit.sv
// Instruction fetch unit for a pipelined RISC-V style core.
// Issues instruction reads, delivers fetched words into IF/ID,
// buffers a word while the hazard unit stalls IF, drains an
// outstanding read after a redirect, and parks itself on halt.
module fetch_unit #(
  parameter logic [31:0] PC0 = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall_IF,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic        fetch_valid,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        j_en,
  output logic        b_en,
  output logic        flush_IF_ID
);

  // Fetch addresses are always word aligned, including the reset address.
  localparam logic [31:0] PC0_ALIGNED = PC0 & 32'hFFFF_FFFC;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pcReg;
  logic [31:0] w_nextPc;
  logic [31:0] r_holdBuf;
  logic [31:0] w_nextHoldBuf;
  logic [31:0] r_pendingPc;
  logic [31:0] w_nextPendingPc;

  logic        w_deliver;
  logic [31:0] w_deliverWord;
  logic        w_flush;
  logic [31:0] w_redirectTarget;
  logic [31:0] w_pcInc;
  logic [6:0]  w_opcode;

  assign w_redirectTarget = redirect_pc & 32'hFFFF_FFFC;
  assign w_pcInc          = r_pcReg + 32'd4;
  assign w_opcode         = w_deliverWord[6:0];

  // Next-state logic; redirect beats halt, halt beats stall, stall beats ihit.
  always_comb begin
    w_nextState     = r_state;
    w_nextPc        = r_pcReg;
    w_nextHoldBuf   = r_holdBuf;
    w_nextPendingPc = r_pendingPc;
    w_deliver       = 1'b0;
    w_deliverWord   = 32'h0;
    w_flush         = 1'b0;
    case (r_state)
      FETCH: begin
        if (redirect_en) begin
          w_flush = 1'b1;
          if (ihit) begin
            w_nextPc = w_redirectTarget;
          end else begin
            w_nextPendingPc = w_redirectTarget;
            w_nextState     = DRAIN;
          end
        end else if (halt) begin
          w_nextState = HALTED;
        end else if (stall_IF) begin
          if (ihit) begin
            w_nextHoldBuf = imemload;
            w_nextState   = HOLD;
          end
        end else if (ihit) begin
          w_deliver     = 1'b1;
          w_deliverWord = imemload;
          w_nextPc      = w_pcInc;
        end
      end
      HOLD: begin
        if (redirect_en) begin
          w_flush       = 1'b1;
          w_nextPc      = w_redirectTarget;
          w_nextHoldBuf = 32'h0;
          w_nextState   = FETCH;
        end else if (halt) begin
          w_nextState = HALTED;
        end else if (!stall_IF) begin
          w_deliver     = 1'b1;
          w_deliverWord = r_holdBuf;
          w_nextPc      = w_pcInc;
          w_nextState   = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_en) begin
          w_flush         = 1'b1;
          w_nextPendingPc = w_redirectTarget;
          if (ihit) begin
            w_nextPc    = w_redirectTarget;
            w_nextState = FETCH;
          end
        end else if (halt) begin
          w_nextState = HALTED;
        end else if (ihit) begin
          w_nextPc    = r_pendingPc;
          w_nextState = FETCH;
        end
      end
      HALTED: begin
        w_nextState = HALTED;
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  // State and datapath registers; reset abandons any held or pending work.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= FETCH;
      r_pcReg     <= PC0_ALIGNED;
      r_holdBuf   <= 32'h0;
      r_pendingPc <= 32'h0;
    end else begin
      r_state     <= w_nextState;
      r_pcReg     <= w_nextPc;
      r_holdBuf   <= w_nextHoldBuf;
      r_pendingPc <= w_nextPendingPc;
    end
  end

  // Output drive; reset forces a quiet interface pointing at the reset address.
  always_comb begin
    imemREN     = 1'b0;
    imemaddr    = PC0_ALIGNED;
    fetch_valid = 1'b0;
    pc          = 32'h0;
    instr       = 32'h0;
    j_en        = 1'b0;
    b_en        = 1'b0;
    flush_IF_ID = 1'b0;
    if (!RST) begin
      imemREN     = (r_state == FETCH) || (r_state == DRAIN);
      imemaddr    = {r_pcReg[31:2], 2'b00};
      fetch_valid = w_deliver;
      flush_IF_ID = w_flush;
      if (w_deliver) begin
        pc    = r_pcReg;
        instr = w_deliverWord;
        j_en  = (w_opcode == OPC_JAL) || (w_opcode == OPC_JALR);
        b_en  = (w_opcode == OPC_BRANCH);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by random
// traffic, all compared against a behavioural fetch model.
module tb_fetch_unit;

  localparam logic [31:0] TB_PC0 = 32'h0000_0000;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall_IF;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        j_en;
  logic        b_en;
  logic        flush_IF_ID;

  int errors = 0;
  int checks = 0;

  // Model of the fetcher: where the next read goes, and whether a word
  // is being held, a stale read is being drained, or fetch has stopped.
  logic [31:0] mNextAddr;
  logic        mHeld;
  logic [31:0] mHeldWord;
  logic        mDraining;
  logic [31:0] mTarget;
  logic        mHalted;

  fetch_unit #(.PC0(TB_PC0)) dut (
    .CLK(CLK),
    .RST(RST),
    .ihit(ihit),
    .imemload(imemload),
    .stall_IF(stall_IF),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .fetch_valid(fetch_valid),
    .pc(pc),
    .instr(instr),
    .j_en(j_en),
    .b_en(b_en),
    .flush_IF_ID(flush_IF_ID)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic isJump(input logic [31:0] w);
    return (w[6:0] == 7'h6F) || (w[6:0] == 7'h67);
  endfunction

  function automatic logic isBranch(input logic [31:0] w);
    return w[6:0] == 7'h63;
  endfunction

  function automatic logic [31:0] makeWord();
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    case ($urandom_range(0, 3))
      0: opc = 7'h6F;
      1: opc = 7'h67;
      2: opc = 7'h63;
      default: opc = r[6:0];
    endcase
    return {r[31:7], opc};
  endfunction

  // Drive one cycle of inputs, let outputs settle, compare with the model.
  task automatic applyStimulus(input logic rst, input logic hit, input logic [31:0] load,
                               input logic stall, input logic redir,
                               input logic [31:0] rpc, input logic hlt);
    logic        eRen;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eWord;
    logic [31:0] ePc;
    logic        eFlush;
    RST = rst; ihit = hit; imemload = load; stall_IF = stall;
    redirect_en = redir; redirect_pc = rpc; halt = hlt;
    #3;
    eRen = 1'b0; eAddr = mNextAddr; eValid = 1'b0; eWord = 32'h0; ePc = 32'h0; eFlush = 1'b0;
    if (rst) begin
      eAddr = TB_PC0;
    end else if (!mHalted) begin
      eRen   = !mHeld;
      eFlush = redir;
      if (!redir && !hlt && !mDraining) begin
        if (mHeld && !stall) begin
          eValid = 1'b1; eWord = mHeldWord; ePc = mNextAddr;
        end else if (!mHeld && hit && !stall) begin
          eValid = 1'b1; eWord = load; ePc = mNextAddr;
        end
      end
    end
    checkOutput("imemREN", {31'h0, imemREN}, {31'h0, eRen});
    checkOutput("imemaddr", imemaddr, eAddr);
    checkOutput("fetch_valid", {31'h0, fetch_valid}, {31'h0, eValid});
    checkOutput("pc", pc, ePc);
    checkOutput("instr", instr, eWord);
    checkOutput("j_en", {31'h0, j_en}, {31'h0, eValid && isJump(eWord)});
    checkOutput("b_en", {31'h0, b_en}, {31'h0, eValid && isBranch(eWord)});
    checkOutput("flush_IF_ID", {31'h0, flush_IF_ID}, {31'h0, eFlush});
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic tick();
    logic [31:0] target;
    target = redirect_pc & 32'hFFFF_FFFC;
    if (RST) begin
      mNextAddr = TB_PC0; mHeld = 1'b0; mHeldWord = 32'h0;
      mDraining = 1'b0; mTarget = 32'h0; mHalted = 1'b0;
    end else if (mHalted) begin
      mHalted = 1'b1;
    end else if (redirect_en) begin
      if (mHeld) begin
        mHeld = 1'b0; mNextAddr = target;
      end else if (mDraining) begin
        mTarget = target;
        if (ihit) begin mNextAddr = target; mDraining = 1'b0; end
      end else if (ihit) begin
        mNextAddr = target;
      end else begin
        mDraining = 1'b1; mTarget = target;
      end
    end else if (halt) begin
      mHalted = 1'b1;
    end else if (mDraining) begin
      if (ihit) begin mNextAddr = mTarget; mDraining = 1'b0; end
    end else if (mHeld) begin
      if (!stall_IF) begin mHeld = 1'b0; mNextAddr = mNextAddr + 32'd4; end
    end else if (ihit) begin
      if (stall_IF) begin mHeld = 1'b1; mHeldWord = imemload; end
      else mNextAddr = mNextAddr + 32'd4;
    end
    @(posedge CLK);
    #1;
  endtask

  // Directed scenarios, then random traffic
  initial begin
    logic [31:0] w;
    mNextAddr = TB_PC0; mHeld = 1'b0; mHeldWord = 32'h0;
    mDraining = 1'b0; mTarget = 32'h0; mHalted = 1'b0;

    // reset state
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("reset_addr", imemaddr, 32'h0);
      tick();
    end

    // streaming fetch from address 0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_0013 + i, 1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("stream_pc", pc, 32'(i * 4));
      tick();
    end

    // stall while a hit arrives at 0x10
    w = 32'h1234_5013;
    applyStimulus(1'b0, 1'b1, w, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_addr", imemaddr, 32'h10);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 32'hBAD0_0013, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("hold_ren", {31'h0, imemREN}, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'hBAD1_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("hold_instr", instr, w);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("after_hold_addr", imemaddr, 32'h14);
    tick();

    // walk to 0x20, then redirect while the read is outstanding
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
    checkOutput("redirect_flush", {31'h0, flush_IF_ID}, 32'h1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("drain_addr", imemaddr, 32'h20);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_006F, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("drain_discard", {31'h0, fetch_valid}, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("redirect_addr", imemaddr, 32'h100);
    tick();

    // predecode of JAL then BEQ
    applyStimulus(1'b0, 1'b1, 32'h0000_006F, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("jal_j", {31'h0, j_en}, 32'h1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("beq_b", {31'h0, b_en}, 32'h1);
    tick();

    // address wrap at the top of memory
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_addr", imemaddr, 32'h0);
    tick();

    // halt at 0x40, ignore a later redirect, recover through reset
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b1, 32'h800, 1'b0);
    checkOutput("halted_ren", {31'h0, imemREN}, 32'h0);
    checkOutput("halted_noflush", {31'h0, flush_IF_ID}, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("halted_addr", imemaddr, 32'h40);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("post_reset_addr", imemaddr, TB_PC0);
    tick();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic rst;
      rst = mHalted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 59) == 0);
      applyStimulus(rst, $urandom_range(0, 3) != 0, makeWord(),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                    $urandom(), $urandom_range(0, 49) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
